// File: rtl/match_event_logger.sv
// -----------------------------------------------------------------------------
// match_event_logger
//
// Turns each rising edge of the sequence detector's match flag into an event
// record {timestamp, event index}. Records are queued in a small
// first-word-fall-through FIFO and drained over a valid/ready handshake.
// Events that arrive while the FIFO is full are dropped and counted in a
// saturating counter.
//
// Ports
//   clk            : clock; all state changes on the rising edge
//   rst_n          : asynchronous active-low reset
//   match_in       : detector flag (level); an event is its 0->1 transition
//   clear          : synchronous clear of FIFO, counters and timestamp
//   evt_ready      : consumer accepts the head record
//   evt_valid      : FIFO non-empty; head record is presented
//   evt_timestamp  : timestamp of the head record
//   evt_index      : event index of the head record
//   match_count    : events detected since reset/clear (wraps)
//   overflow_count : events dropped on a full FIFO (saturates)
//   fifo_level     : entries currently stored, 0..DEPTH
// -----------------------------------------------------------------------------
module match_event_logger #(
   parameter int TS_WIDTH  = 16,
   parameter int CNT_WIDTH = 8,
   parameter int DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   match_in,
   input  logic                   clear,
   input  logic                   evt_ready,
   output logic                   evt_valid,
   output logic [TS_WIDTH-1:0]    evt_timestamp,
   output logic [CNT_WIDTH-1:0]   evt_index,
   output logic [CNT_WIDTH-1:0]   match_count,
   output logic [CNT_WIDTH-1:0]   overflow_count,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int RW = TS_WIDTH + CNT_WIDTH;
   localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

   // State
   logic [TS_WIDTH-1:0]  ts_q, ts_d;
   logic                 match_prev_q, match_prev_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic [CNT_WIDTH-1:0] match_count_q, match_count_d;
   logic [CNT_WIDTH-1:0] overflow_q, overflow_d;

   // Record storage; no reset needed since entries are only read when valid
   logic [RW-1:0]        mem_q [DEPTH];

   // Per-cycle decisions
   logic evt_det;
   logic pop;
   logic full;
   logic push_en;

   always_comb begin
      evt_det       = match_in & ~match_prev_q;
      pop           = (level_q != '0) & evt_ready;
      full          = (level_q == LEVEL_FULL);
      push_en       = 1'b0;

      // Edge history always follows the input, even during clear, so a flag
      // held high across a clear does not produce a late event.
      match_prev_d  = match_in;
      ts_d          = ts_q + TS_WIDTH'(1);
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      level_d       = level_q;
      match_count_d = match_count_q;
      overflow_d    = overflow_q;

      if (clear) begin
         ts_d          = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         level_d       = '0;
         match_count_d = '0;
         overflow_d    = '0;
      end else begin
         if (evt_det) begin
            match_count_d = match_count_q + CNT_WIDTH'(1);
            // A full FIFO still accepts the record if the head leaves this cycle
            if (!full || pop) begin
               push_en = 1'b1;
            end else if (overflow_q != '1) begin
               overflow_d = overflow_q + CNT_WIDTH'(1);
            end
         end

         if (push_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end

         case ({push_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q          <= '0;
         match_prev_q  <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         match_count_q <= '0;
         overflow_q    <= '0;
      end else begin
         ts_q          <= ts_d;
         match_prev_q  <= match_prev_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         match_count_q <= match_count_d;
         overflow_q    <= overflow_d;
      end
   end

   // Record captures the pre-edge timestamp and the pre-increment index
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_ptr_q] <= {ts_q, match_count_q};
      end
   end

   // First-word-fall-through head; valid depends only on registered level
   assign evt_valid      = (level_q != '0);
   assign evt_timestamp  = mem_q[rd_ptr_q][RW-1:CNT_WIDTH];
   assign evt_index      = mem_q[rd_ptr_q][CNT_WIDTH-1:0];
   assign match_count    = match_count_q;
   assign overflow_count = overflow_q;
   assign fifo_level     = level_q;

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the 3-bit symbol sequence detector's `sequence_found` output. It converts each rising edge of the detector flag into an event record and queues it in a small first-word-fall-through FIFO. Each record holds a free-running timestamp and a running event index. Records are drained by software-facing logic over a valid/ready handshake, and the block keeps saturating counters for dropped events.

## Interface
- `TS_WIDTH`, 16: width of the free-running timestamp counter and the timestamp field.
- `CNT_WIDTH`, 8: width of the event index, `match_count` and `overflow_count`.
- `DEPTH`, 4: FIFO entries; must be a power of 2, ≥2.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `match_in` in 1: detector flag. This is a level; an event is its 0→1 transition.
- `clear` in 1: synchronous clear of FIFO, counters and timestamp.
- `evt_ready` in 1: consumer accepts the head record.
- `evt_valid` out 1: FIFO non-empty; the head record is presented.
- `evt_timestamp` out TS_WIDTH: timestamp of the head record.
- `evt_index` out CNT_WIDTH: index of the head record.
- `match_count` out CNT_WIDTH: detected events since reset/clear. Wraps.
- `overflow_count` out CNT_WIDTH: events dropped on a full FIFO. Saturates at all-ones.
- `fifo_level` out $clog2(DEPTH)+1: entries currently stored, 0..DEPTH.

## Operation
- Reset (async): `ts`, `match_d`, pointers, `fifo_level`, `match_count` and `overflow_count` all go to 0.
  - `evt_valid` = 0.
  - `evt_timestamp` and `evt_index` are don't-care while `evt_valid` = 0; the bench checks them only when valid.
- Timestamp: `ts` increments by 1 every cycle. It wraps from 2^TS_WIDTH−1 to 0.
- Edge detect:
  - `match_d` <= `match_in` every cycle, including during `clear`.
  - event = `match_in` & ~`match_d`.
  - A flag held high produces exactly one event. Because `match_d` resets to 0, `match_in` = 1 at the first edge after reset is an event.
- On an event with `clear` = 0:
  - Record = {`ts` current value, `match_count` current value}. The index is pre-increment, so the first event gets index 0.
  - `match_count` <= `match_count`+1.
  - The record is pushed if accepted (see FIFO rules).
- FIFO rules (decided on the pre-edge level):
  - pop = `evt_valid` & `evt_ready`.
  - Push is accepted if level < DEPTH, or if level = DEPTH and pop is asserted in the same cycle.
  - A rejected push drops the record and increments `overflow_count` (saturating). `match_count` still increments.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Outputs: `evt_valid` = (`fifo_level` != 0). `evt_timestamp`/`evt_index` are read combinationally from the entry at the read pointer.
- Pop when empty: `evt_ready` is ignored.
- `clear` (highest priority after reset):
  - Level and pointers → 0, `ts` → 0, `match_count` → 0, `overflow_count` → 0.
  - Any event and any pop in that cycle are discarded.
  - `evt_ready` is ignored.

## Timing
- Event latency: an event sampled at edge N is written at edge N. `evt_valid`, with that record at the head if the FIFO was empty, is visible in the cycle following edge N.
- Timestamp semantics: `evt_timestamp` equals the `ts` value in the cycle before edge N.
- Handshake:
  - `evt_valid` and the head fields stay stable until a pop.
  - The consumer may hold `evt_ready` high permanently. This gives one record per cycle.
  - No combinational path from `evt_ready` to `evt_valid`.
- Counters update at the same edge as the push decision. `fifo_level` reflects the edge's push/pop in the next cycle.
- Mid-operation reset: all state is lost immediately and outputs go to reset values asynchronously.

## Test plan
- Reset, then pulse `match_in` high for 3 cycles in the cycle where `ts`=5, `evt_ready`=0. Required:
  - exactly one record, {ts=5, idx=0};
  - `evt_valid`=1 the next cycle;
  - `match_count`=1, `fifo_level`=1.
- With `evt_ready`=0, DEPTH=4, issue 6 events, each separated by one low cycle. Required:
  - level=4 and `match_count`=6;
  - `overflow_count`=2;
  - drained records have indices 0,1,2,3 in order.
- FIFO full, then an event and `evt_ready`=1 in the same cycle. Required:
  - the push is accepted and level stays 4;
  - `overflow_count` is unchanged;
  - the new record appears last after the drain.
- `evt_ready` held at 1 while an event arrives every other cycle. Required:
  - each record is popped in the cycle after its push;
  - level alternates 0/1;
  - timestamps differ by exactly 2.
- Run `ts` to 0xFFFF and hit an event there (TS_WIDTH=16). Run 300 events with CNT_WIDTH=8 and the FIFO always draining. Required:
  - the timestamp wraps to 0x0000 on the next cycle;
  - `match_count`=44 (wrapped);
  - `overflow_count`=0.
- Assert `clear` with 3 entries queued while `match_in` rises in the same cycle. Required:
  - next cycle `evt_valid`=0 and all counts are 0;
  - `match_in` held high produces no later event.
- Assert `rst_n` low mid-drain. Required: `evt_valid` is 0 immediately, without waiting for a clock edge.
